// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: FSM encoding, descriptor layout, config record.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package layer_sched_pkg;

    // Descriptor layout as pushed by software, MSB first.
    localparam int DESC_W        = 53;
    localparam int SORTER_OP_BIT = 52;
    localparam int LAYERS_LSB    = 44;
    localparam int X_LSB         = 36;
    localparam int Y_LSB         = 28;
    localparam int ADDR_LSB      = 16;
    localparam int STORE_LSB     = 8;
    localparam int JUMP_LSB      = 0;

    // Configuration field widths.
    localparam int LAYERS_W = 8;
    localparam int X_W      = 8;
    localparam int Y_W      = 8;
    localparam int ADDR_W   = 12;
    localparam int STORE_W  = 8;
    localparam int JUMP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIRE = 2'd2,
        ST_WAIT = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic                sorter_op;
        logic [LAYERS_W-1:0] output_layers;
        logic [X_W-1:0]      x_length;
        logic [Y_W-1:0]      y_length;
        logic [ADDR_W-1:0]   addr_start;
        logic [STORE_W-1:0]  store_length;
        logic [JUMP_W-1:0]   jump_length;
    } layer_cfg_t;

    function automatic layer_cfg_t desc_to_cfg(input logic [DESC_W-1:0] d);
        layer_cfg_t c;
        c.sorter_op     = d[SORTER_OP_BIT];
        c.output_layers = d[LAYERS_LSB +: LAYERS_W];
        c.x_length      = d[X_LSB +: X_W];
        c.y_length      = d[Y_LSB +: Y_W];
        c.addr_start    = d[ADDR_LSB +: ADDR_W];
        c.store_length  = d[STORE_LSB +: STORE_W];
        c.jump_length   = d[JUMP_LSB +: JUMP_W];
        return c;
    endfunction

    // A layer with no output layers or an empty plane has nothing to compute.
    function automatic logic cfg_valid(input layer_cfg_t c);
        return (c.output_layers != '0) && (c.x_length != '0) && (c.y_length != '0);
    endfunction

endpackage

// File: rtl/sched_desc_fifo.sv
// Descriptor FIFO with first-word-fall-through read, synchronous flush and occupancy level.
// Latency: a push is visible at the head one cycle later; pop takes effect on the clock edge.
// Backpressure: pushes while full are dropped (o_full); flush wins over push and pop in the same cycle.
// Ports: i_push/i_push_dat write side, i_pop/o_pop_dat read side, i_flush empties, o_level/o_full/o_empty status.
module sched_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 53
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_dat,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign o_full    = (level_q == LW'(DEPTH));
    assign o_empty   = (level_q == '0);
    assign o_level   = level_q;
    assign o_pop_dat = mem_q[rd_ptr_q];

    assign push_ok = i_push & ~o_full  & ~i_flush;
    assign pop_ok  = i_pop  & ~o_empty & ~i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_dat;
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: queues layer descriptors and hands them one at a time to the output address generator.
// Latency: IDLE->LOAD->FIRE gives the enable pulse 2 cycles after dispatch starts; min 4 cycles between pulses.
// Backpressure: o_desc_rdy drops while the descriptor FIFO is full; waits on i_calculate_end or the watchdog.
// Ports: i_desc_vld/o_desc_rdy/i_desc push side; i_run/i_abort control; o_calculate_enable + o_* config to the
//        generator, i_calculate_end back; o_busy/o_layer_done/o_layer_cnt/o_err_desc/o_timeout/o_fifo_level status.
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WDT_CYCLES = 65535
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_desc_vld,
    output logic                o_desc_rdy,
    input  logic [DESC_W-1:0]   i_desc,
    input  logic                i_run,
    input  logic                i_abort,
    output logic                o_calculate_enable,
    output logic                o_sorter_op,
    output logic [LAYERS_W-1:0] o_output_layers,
    output logic [X_W-1:0]      o_x_length,
    output logic [Y_W-1:0]      o_y_length,
    output logic [ADDR_W-1:0]   o_addr_start_s,
    output logic [STORE_W-1:0]  o_store_length,
    output logic [JUMP_W-1:0]   o_jump_length,
    input  logic                i_calculate_end,
    output logic                o_busy,
    output logic                o_layer_done,
    output logic [7:0]          o_layer_cnt,
    output logic                o_err_desc,
    output logic                o_timeout,
    output logic [4:0]          o_fifo_level
);
    localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    sched_state_e      state_q, state_d;
    layer_cfg_t        cfg_q, cfg_d;
    logic              calc_en_q, calc_en_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       wdt_q, wdt_d;

    logic              fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DESC_W-1:0] fifo_dat;
    logic [LVL_W-1:0]  fifo_level;
    layer_cfg_t        head_cfg;

    sched_desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (i_desc_vld),
        .i_push_dat (i_desc),
        .i_pop      (fifo_pop),
        .o_pop_dat  (fifo_dat),
        .i_flush    (fifo_flush),
        .o_level    (fifo_level),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    assign head_cfg = desc_to_cfg(fifo_dat);

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        calc_en_d  = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        wdt_d      = wdt_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        if (i_abort) begin
            // The generator is not recalled; only the queue and the FSM are cleared.
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_run && !fifo_empty) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    fifo_pop = 1'b1;
                    cfg_d    = head_cfg;
                    if (cfg_valid(head_cfg)) begin
                        state_d   = ST_FIRE;
                        calc_en_d = 1'b1;     // enable is high for the whole FIRE cycle
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_d = ST_WAIT;
                    wdt_d   = '0;
                end
                ST_WAIT: begin
                    // End flag only counts here; it is stale in every other state.
                    if (i_calculate_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end else if (wdt_q == WDT_LAST) begin
                        state_d    = ST_IDLE;
                        tmo_d      = 1'b1;
                        fifo_flush = 1'b1;
                    end else begin
                        wdt_d = wdt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            calc_en_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            wdt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            calc_en_q <= calc_en_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            wdt_q     <= wdt_d;
        end
    end

    assign o_desc_rdy         = ~fifo_full;
    assign o_busy             = (state_q != ST_IDLE);
    assign o_calculate_enable = calc_en_q;
    assign o_layer_done       = done_q;
    assign o_layer_cnt        = cnt_q;
    assign o_err_desc         = err_q;
    assign o_timeout          = tmo_q;
    assign o_fifo_level       = 5'(fifo_level);
    assign o_sorter_op        = cfg_q.sorter_op;
    assign o_output_layers    = cfg_q.output_layers;
    assign o_x_length         = cfg_q.x_length;
    assign o_y_length         = cfg_q.y_length;
    assign o_addr_start_s     = cfg_q.addr_start;
    assign o_store_length     = cfg_q.store_length;
    assign o_jump_length      = cfg_q.jump_length;

endmodule

// File: tb/tb_layer_sched.sv
// Self-checking bench for layer_sched with a scoreboard of expected enable-pulse configurations.
// Latency: n/a (bench).
// Backpressure: the address generator is modelled with a programmable end delay (0 = never ends).
module tb_layer_sched;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_desc_vld;
    logic        o_desc_rdy;
    logic [52:0] i_desc;
    logic        i_run;
    logic        i_abort;
    logic        o_calculate_enable;
    logic        o_sorter_op;
    logic [7:0]  o_output_layers;
    logic [7:0]  o_x_length;
    logic [7:0]  o_y_length;
    logic [11:0] o_addr_start_s;
    logic [7:0]  o_store_length;
    logic [7:0]  o_jump_length;
    logic        i_calculate_end;
    logic        o_busy;
    logic        o_layer_done;
    logic [7:0]  o_layer_cnt;
    logic        o_err_desc;
    logic        o_timeout;
    logic [4:0]  o_fifo_level;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pulse  = 0;
    int          n_done   = 0;
    int          n_end    = 0;
    int          end_delay = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    logic [52:0] exp_q[$];
    logic [52:0] exp_cfg;

    always #5 i_clk = ~i_clk;

    layer_sched #(
        .FIFO_DEPTH (4),
        .WDT_CYCLES (100)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_desc_vld         (i_desc_vld),
        .o_desc_rdy         (o_desc_rdy),
        .i_desc             (i_desc),
        .i_run              (i_run),
        .i_abort            (i_abort),
        .o_calculate_enable (o_calculate_enable),
        .o_sorter_op        (o_sorter_op),
        .o_output_layers    (o_output_layers),
        .o_x_length         (o_x_length),
        .o_y_length         (o_y_length),
        .o_addr_start_s     (o_addr_start_s),
        .o_store_length     (o_store_length),
        .o_jump_length      (o_jump_length),
        .i_calculate_end    (i_calculate_end),
        .o_busy             (o_busy),
        .o_layer_done       (o_layer_done),
        .o_layer_cnt        (o_layer_cnt),
        .o_err_desc         (o_err_desc),
        .o_timeout          (o_timeout),
        .o_fifo_level       (o_fifo_level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [52:0] mk(input logic s, input logic [7:0] l, input logic [7:0] x,
                                       input logic [7:0] y, input logic [11:0] a,
                                       input logic [7:0] st, input logic [7:0] j);
        return {s, l, x, y, a, st, j};
    endfunction

    function automatic logic [52:0] cfg_out();
        return {o_sorter_op, o_output_layers, o_x_length, o_y_length,
                o_addr_start_s, o_store_length, o_jump_length};
    endfunction

    // Address generator: sticky end flag, cleared on the edge after the enable pulse,
    // raised again end_delay cycles after the pulse.
    initial begin : end_gen
        i_calculate_end = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_calculate_enable) begin
                @(posedge i_clk);
                #1 i_calculate_end = 1'b0;
                if (end_delay > 0) begin
                    repeat (end_delay - 1) @(posedge i_clk);
                    #1 i_calculate_end = 1'b1;
                    n_end++;
                end
            end
        end
    end

    // Scoreboard side: every enable pulse must carry the next expected descriptor.
    always @(negedge i_clk) begin
        cyc++;
        if (i_rst_n && o_calculate_enable) begin
            chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_cfg = exp_q.pop_front();
                chk("pulse_cfg", 64'(cfg_out()), 64'(exp_cfg));
            end
            if (n_pulse > 0) chk("pulse_gap", 64'((cyc - last_pulse_cyc) >= 4), 64'd1);
            last_pulse_cyc = cyc;
            n_pulse++;
        end
        if (i_rst_n && o_layer_done) begin
            n_done++;
            chk("done_not_early", 64'(n_done <= n_end), 64'd1);
        end
    end

    task automatic push_desc(input logic [52:0] d, input bit expect_fire);
        if (expect_fire && o_desc_rdy) exp_q.push_back(d);
        i_desc     = d;
        i_desc_vld = 1'b1;
        @(posedge i_clk); #1;
        i_desc_vld = 1'b0;
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_calculate_enable && k < budget);
        chk(tag, 64'(o_calculate_enable), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_layer_done && k < budget);
        chk(tag, 64'(o_layer_done), 64'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_rdy"},   64'(o_desc_rdy), 64'd1);
        chk({pfx, "_busy"},  64'(o_busy), 64'd0);
        chk({pfx, "_en"},    64'(o_calculate_enable), 64'd0);
        chk({pfx, "_done"},  64'(o_layer_done), 64'd0);
        chk({pfx, "_cnt"},   64'(o_layer_cnt), 64'd0);
        chk({pfx, "_level"}, 64'(o_fifo_level), 64'd0);
        chk({pfx, "_err"},   64'(o_err_desc), 64'd0);
        chk({pfx, "_tmo"},   64'(o_timeout), 64'd0);
        chk({pfx, "_cfg"},   64'(cfg_out()), 64'd0);
    endtask

    initial begin : safety
        #200000;
        $display("FAIL global_time_limit: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin : main
        int k;
        i_rst_n    = 1'b0;
        i_desc_vld = 1'b0;
        i_desc     = '0;
        i_run      = 1'b0;
        i_abort    = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_values("rst");
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Happy path
        end_delay = 30;
        push_desc(mk(1'b0, 8'd3, 8'd4, 8'd2, 12'h010, 8'd16, 8'd5), 1'b1);
        chk("t1_level", 64'(o_fifo_level), 64'd1);
        i_run = 1'b1;
        wait_done("t1_done", 100);
        chk("t1_cnt", 64'(o_layer_cnt), 64'd1);
        chk("t1_busy", 64'(o_busy), 64'd0);
        chk("t1_cfg_hold", 64'({o_output_layers, o_x_length, o_y_length, o_addr_start_s}),
            64'({8'd3, 8'd4, 8'd2, 12'h010}));
        @(posedge i_clk); #1;
        chk("t1_pulses", 64'(n_pulse), 64'd1);
        i_run = 1'b0;

        // Back-to-back with the end flag left high from the previous layer
        end_delay = 5;
        push_desc(mk(1'b0, 8'd1, 8'd8, 8'd8, 12'h100, 8'd4, 8'd2), 1'b1);
        push_desc(mk(1'b1, 8'd2, 8'd16, 8'd1, 12'h200, 8'd8, 8'd8), 1'b1);
        push_desc(mk(1'b0, 8'd8, 8'd2, 8'd3, 12'hFFF, 8'd255, 8'd1), 1'b1);
        chk("t2_level3", 64'(o_fifo_level), 64'd3);
        i_run = 1'b1;
        for (int i = 0; i < 3; i++) wait_done($sformatf("t2_done%0d", i), 60);
        chk("t2_cnt", 64'(o_layer_cnt), 64'd4);
        @(posedge i_clk); #1;
        chk("t2_level0", 64'(o_fifo_level), 64'd0);
        chk("t2_pulses", 64'(n_pulse), 64'd4);
        chk("t2_dones", 64'(n_done), 64'd4);
        chk("t2_err_clear", 64'(o_err_desc), 64'd0);
        i_run = 1'b0;

        // Zero-length descriptor followed by a valid one
        push_desc(mk(1'b0, 8'd3, 8'd0, 8'd2, 12'h020, 8'd1, 8'd1), 1'b0);
        push_desc(mk(1'b0, 8'd1, 8'd1, 8'd1, 12'h030, 8'd1, 8'd1), 1'b1);
        i_run = 1'b1;
        wait_done("t3_done", 60);
        chk("t3_err", 64'(o_err_desc), 64'd1);
        chk("t3_cnt", 64'(o_layer_cnt), 64'd5);
        @(posedge i_clk); #1;
        chk("t3_pulses", 64'(n_pulse), 64'd5);
        i_run = 1'b0;

        // Watchdog: generator never ends
        end_delay = 0;
        push_desc(mk(1'b0, 8'd2, 8'd2, 8'd2, 12'h040, 8'd1, 8'd1), 1'b1);
        push_desc(mk(1'b0, 8'd2, 8'd2, 8'd2, 12'h050, 8'd1, 8'd1), 1'b0);
        chk("t4_tmo_pre", 64'(o_timeout), 64'd0);
        i_run = 1'b1;
        wait_pulse("t4_pulse", 20);
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_timeout && k < 300);
        chk("t4_wdt_cycles", 64'(k), 64'd101);
        chk("t4_tmo", 64'(o_timeout), 64'd1);
        chk("t4_busy", 64'(o_busy), 64'd0);
        chk("t4_level", 64'(o_fifo_level), 64'd0);
        chk("t4_cnt", 64'(o_layer_cnt), 64'd5);
        @(posedge i_clk); #1;
        chk("t4_dones", 64'(n_done), 64'd5);
        i_run = 1'b0;

        // Full FIFO, then abort in WAIT with a simultaneous push
        for (int i = 0; i < 4; i++)
            push_desc(mk(1'b0, 8'd1, 8'd2, 8'd3, 12'(12'h060 + i), 8'd1, 8'd1), i == 0);
        chk("t5_rdy_full", 64'(o_desc_rdy), 64'd0);
        chk("t5_level4", 64'(o_fifo_level), 64'd4);
        push_desc(mk(1'b0, 8'd9, 8'd9, 8'd9, 12'h0AA, 8'd1, 8'd1), 1'b0);
        chk("t5_level_overflow", 64'(o_fifo_level), 64'd4);
        i_run = 1'b1;
        wait_pulse("t5_pulse", 20);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_abort    = 1'b1;
        i_desc     = mk(1'b0, 8'd5, 8'd5, 8'd5, 12'h0BB, 8'd1, 8'd1);
        i_desc_vld = 1'b1;
        @(posedge i_clk); #1;
        i_abort    = 1'b0;
        i_desc_vld = 1'b0;
        chk("t5_level0", 64'(o_fifo_level), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd0);
        repeat (5) @(posedge i_clk);
        #1;
        chk("t5_level_stays0", 64'(o_fifo_level), 64'd0);
        chk("t5_cnt", 64'(o_layer_cnt), 64'd5);
        chk("t5_dones", 64'(n_done), 64'd5);
        chk("t5_tmo_sticky", 64'(o_timeout), 64'd1);

        // Asynchronous reset in the middle of WAIT
        push_desc(mk(1'b1, 8'd4, 8'd4, 8'd4, 12'h123, 8'd2, 8'd2), 1'b1);
        wait_pulse("t6_pulse", 20);
        @(posedge i_clk); #1;
        @(posedge i_clk); #2;
        chk("t6_busy_pre", 64'(o_busy), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_values("t6");
        @(posedge i_clk); #1;
        i_run   = 1'b0;
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("t6_idle_after", 64'(o_busy), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
